// File: rtl/fir_seq_pkg.sv
// Shared types, sizes and the output saturation helper for the 4-tap FIR sequencer.
package fir_seq_pkg;

    localparam int NUM_TAPS = 4;
    localparam int DATA_W   = 16;
    localparam int ACC_W    = 34;
    localparam int IDX_W    = 2;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT,
        MAC,
        DONE
    } state_t;

    // True when the Q1.15-scaled sum no longer fits in 16 unsigned bits.
    function automatic logic acc_overflow(input logic [ACC_W-1:0] acc);
        return |acc[ACC_W-1:2*DATA_W-1];
    endfunction

    // Drop the 15 fractional bits; clamp to all-ones when the integer part overflows.
    function automatic logic [DATA_W-1:0] saturate(input logic [ACC_W-1:0] acc);
        if (acc_overflow(acc)) begin
            return '1;
        end
        return acc[2*DATA_W-2:DATA_W-1];
    endfunction

endpackage

// File: rtl/fir_mac.sv
// Multiply-accumulate register: 16x16 unsigned product summed into a 34-bit accumulator.
module fir_mac
    import fir_seq_pkg::*;
(
    input  logic              clk,
    input  logic              n_rst,
    input  logic              clr,
    input  logic              en,
    input  logic [DATA_W-1:0] sample,
    input  logic [DATA_W-1:0] coef,
    output logic [DATA_W-1:0] sat_out,
    output logic              overflow
);

    logic [ACC_W-1:0]    acc_reg;
    logic [2*DATA_W-1:0] product;

    assign product = {{DATA_W{1'b0}}, sample} * {{DATA_W{1'b0}}, coef};

    // Accumulator: clear wins over enable so a new sample always starts from zero.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            acc_reg <= '0;
        end else if (clr) begin
            acc_reg <= '0;
        end else if (en) begin
            acc_reg <= acc_reg + {{(ACC_W-2*DATA_W){1'b0}}, product};
        end
    end

    assign sat_out  = saturate(acc_reg);
    assign overflow = acc_overflow(acc_reg);

endmodule

// File: rtl/fir_sequencer.sv
// 4-tap FIR sequencer: loads coefficients from a bus slave, shifts samples in and
// runs a 4-cycle multiply-accumulate per sample, with one-deep request buffering.
module fir_sequencer
    import fir_seq_pkg::*;
(
    input  logic              clk,
    input  logic              n_rst,
    input  logic              data_ready,
    input  logic              new_coefficient_set,
    input  logic [DATA_W-1:0] sample_data,
    input  logic [DATA_W-1:0] fir_coefficient,
    output logic [IDX_W-1:0]  coefficient_num,
    output logic              modwait,
    output logic [DATA_W-1:0] fir_out,
    output logic              err
);

    state_t            state_reg;
    logic [IDX_W-1:0]  idx_reg;
    logic [DATA_W-1:0] tap_reg  [NUM_TAPS];
    logic [DATA_W-1:0] coef_reg [NUM_TAPS];
    logic              sample_pend_reg;
    logic              coef_pend_reg;
    // An extra pulse is charged to the sample that absorbed it: it is noted in
    // overrun_pend_reg and moves into overrun_reg when that pending sample is shifted in.
    logic              overrun_pend_reg;
    logic              overrun_reg;
    logic [DATA_W-1:0] fir_out_reg;
    logic              err_reg;
    logic              modwait_reg;

    logic              sample_req;
    logic              coef_req;
    logic              mac_clr;
    logic              mac_en;
    logic [DATA_W-1:0] mac_sat;
    logic              mac_ovf;

    assign sample_req = data_ready | sample_pend_reg;
    assign coef_req   = new_coefficient_set | coef_pend_reg;
    assign mac_clr    = (state_reg == SHIFT);
    assign mac_en     = (state_reg == MAC);

    fir_mac u_mac (
        .clk      (clk),
        .n_rst    (n_rst),
        .clr      (mac_clr),
        .en       (mac_en),
        .sample   (tap_reg[idx_reg]),
        .coef     (coef_reg[idx_reg]),
        .sat_out  (mac_sat),
        .overflow (mac_ovf)
    );

    // Tap delay line and coefficient bank, written only in SHIFT and LOAD respectively.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < NUM_TAPS; i++) begin
                tap_reg[i]  <= '0;
                coef_reg[i] <= '0;
            end
        end else begin
            if (state_reg == LOAD) begin
                coef_reg[idx_reg] <= fir_coefficient;
            end
            if (state_reg == SHIFT) begin
                tap_reg[0] <= sample_data;
                for (int i = 1; i < NUM_TAPS; i++) begin
                    tap_reg[i] <= tap_reg[i-1];
                end
            end
        end
    end

    // Control FSM with request buffering and registered status outputs.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_reg        <= IDLE;
            idx_reg          <= '0;
            sample_pend_reg  <= 1'b0;
            coef_pend_reg    <= 1'b0;
            overrun_pend_reg <= 1'b0;
            overrun_reg      <= 1'b0;
            fir_out_reg      <= '0;
            err_reg          <= 1'b0;
            modwait_reg      <= 1'b0;
        end else begin
            if (data_ready && sample_pend_reg) begin
                overrun_pend_reg <= 1'b1;
            end
            if (state_reg != IDLE) begin
                if (data_ready) begin
                    sample_pend_reg <= 1'b1;
                end
                if (new_coefficient_set) begin
                    coef_pend_reg <= 1'b1;
                end
            end
            case (state_reg)
                IDLE: begin
                    if (coef_req) begin
                        state_reg     <= LOAD;
                        idx_reg       <= '0;
                        coef_pend_reg <= 1'b0;
                        modwait_reg   <= 1'b1;
                        if (data_ready) begin
                            sample_pend_reg <= 1'b1;
                        end
                    end else if (sample_req) begin
                        state_reg       <= SHIFT;
                        sample_pend_reg <= 1'b0;
                        modwait_reg     <= 1'b1;
                    end else begin
                        modwait_reg <= 1'b0;
                    end
                end
                LOAD: begin
                    idx_reg <= idx_reg + 2'd1;
                    if (idx_reg == 2'd3) begin
                        state_reg   <= IDLE;
                        modwait_reg <= sample_req | coef_req;
                    end
                end
                SHIFT: begin
                    state_reg        <= MAC;
                    idx_reg          <= '0;
                    overrun_reg      <= overrun_pend_reg;
                    overrun_pend_reg <= 1'b0;
                end
                MAC: begin
                    idx_reg <= idx_reg + 2'd1;
                    if (idx_reg == 2'd3) begin
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    fir_out_reg <= mac_sat;
                    err_reg     <= mac_ovf | overrun_reg;
                    overrun_reg <= 1'b0;
                    state_reg   <= IDLE;
                    modwait_reg <= sample_req | coef_req;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign coefficient_num = (state_reg == LOAD) ? idx_reg : '0;
    assign modwait         = modwait_reg;
    assign fir_out         = fir_out_reg;
    assign err             = err_reg;

endmodule
